// File: rtl/programmable_sequence_detector.sv
// Serial pattern matcher with a runtime-loadable pattern, length and overlap
// mode, plus a saturating count of matches.
module programmable_sequence_detector #(
  parameter int MAX_LEN = 8,
  parameter int CNT_W   = 8,
  localparam int LEN_W  = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               bit_valid,
  input  logic               new_bit,
  input  logic               cfg_we,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  output logic               detected,
  output logic [CNT_W-1:0]   match_count,
  output logic               count_sat
);

  localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(MAX_LEN);
  localparam logic [CNT_W-1:0] CNT_ONES = {CNT_W{1'b1}};

  logic [MAX_LEN-1:0] pattern_q;
  logic [LEN_W-1:0]   len_q;
  logic               overlap_q;
  logic [MAX_LEN-1:0] history_q;
  logic [LEN_W-1:0]   fill_q;
  logic               detected_q;
  logic [CNT_W-1:0]   match_count_q;

  logic [MAX_LEN-1:0] history_next;
  logic [LEN_W-1:0]   fill_next;
  logic [LEN_W-1:0]   cfg_len_clamped;
  logic [MAX_LEN-1:0] len_mask;
  logic               match;

  // Only the low len bits of history and pattern take part in the comparison.
  always_comb begin
    len_mask = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      len_mask[i] = (i < int'(len_q));
    end
  end

  always_comb begin
    history_next    = {history_q[MAX_LEN-2:0], new_bit};
    fill_next       = (fill_q == LEN_MAX) ? LEN_MAX : fill_q + LEN_W'(1);
    cfg_len_clamped = (cfg_len > LEN_MAX) ? LEN_MAX : cfg_len;
    match           = bit_valid && (len_q != '0) && (fill_next >= len_q) &&
                      (((history_next ^ pattern_q) & len_mask) == '0);
  end

  // Reset outranks a config write, which in turn swallows any bit that cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      pattern_q     <= '0;
      len_q         <= LEN_MAX;
      overlap_q     <= 1'b1;
      history_q     <= '0;
      fill_q        <= '0;
      detected_q    <= 1'b0;
      match_count_q <= '0;
    end else if (cfg_we) begin
      pattern_q     <= cfg_pattern;
      len_q         <= cfg_len_clamped;
      overlap_q     <= cfg_overlap;
      history_q     <= '0;
      fill_q        <= '0;
      detected_q    <= 1'b0;
      match_count_q <= '0;
    end else if (bit_valid) begin
      history_q  <= history_next;
      fill_q     <= (match && !overlap_q) ? '0 : fill_next;
      detected_q <= match;
      if (match && (match_count_q != CNT_ONES)) begin
        match_count_q <= match_count_q + CNT_W'(1);
      end
    end else begin
      detected_q <= 1'b0;
    end
  end

  assign detected    = detected_q;
  assign match_count = match_count_q;
  assign count_sat   = (match_count_q == CNT_ONES);

endmodule

// File: tb/tb_programmable_sequence_detector.sv
// Directed-vector bench: stimulus pushes hand-computed expectations into a
// queue that a separate monitor pops and compares one cycle per entry.
module tb_programmable_sequence_detector;

  localparam int MAX_LEN = 8;
  localparam int CNT_W   = 2;
  localparam int LEN_W   = $clog2(MAX_LEN + 1);

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               bit_valid = 1'b0;
  logic               new_bit = 1'b0;
  logic               cfg_we = 1'b0;
  logic [MAX_LEN-1:0] cfg_pattern = '0;
  logic [LEN_W-1:0]   cfg_len = '0;
  logic               cfg_overlap = 1'b1;
  logic               detected;
  logic [CNT_W-1:0]   match_count;
  logic               count_sat;

  typedef struct {
    logic             det;
    logic [CNT_W-1:0] cnt;
    logic             sat;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_vec  = 0;
  int   n_miss = 0;

  programmable_sequence_detector #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) dut (
    .clk(clk),
    .rst(rst),
    .bit_valid(bit_valid),
    .new_bit(new_bit),
    .cfg_we(cfg_we),
    .cfg_pattern(cfg_pattern),
    .cfg_len(cfg_len),
    .cfg_overlap(cfg_overlap),
    .detected(detected),
    .match_count(match_count),
    .count_sat(count_sat)
  );

  always #5 clk = ~clk;

  task automatic push_exp(input logic det, input logic [CNT_W-1:0] cnt, input logic sat);
    exp_t e;
    e.det = det;
    e.cnt = cnt;
    e.sat = sat;
    exp_q.push_back(e);
  endtask

  // Drive one cycle of inputs at the falling edge; the expectation is what the
  // outputs should show just after the following rising edge.
  task automatic apply_stimulus(input logic r, input logic we, input logic v, input logic b,
                                input logic exp_det, input logic [CNT_W-1:0] exp_cnt,
                                input logic exp_sat);
    @(negedge clk);
    rst       = r;
    cfg_we    = we;
    bit_valid = v;
    new_bit   = b;
    push_exp(exp_det, exp_cnt, exp_sat);
  endtask

  task automatic feed(input logic b, input logic exp_det, input logic [CNT_W-1:0] exp_cnt);
    apply_stimulus(1'b0, 1'b0, 1'b1, b, exp_det, exp_cnt, 1'b0);
  endtask

  task automatic feed_sat(input logic b, input logic exp_det, input logic [CNT_W-1:0] exp_cnt,
                          input logic exp_sat);
    apply_stimulus(1'b0, 1'b0, 1'b1, b, exp_det, exp_cnt, exp_sat);
  endtask

  task automatic idle(input logic [CNT_W-1:0] exp_cnt, input logic exp_sat);
    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, exp_cnt, exp_sat);
  endtask

  task automatic reset_cycle();
    apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
  endtask

  task automatic configure(input logic [MAX_LEN-1:0] pat, input logic [LEN_W-1:0] len,
                           input logic ov, input logic v, input logic b);
    @(negedge clk);
    rst         = 1'b0;
    cfg_we      = 1'b1;
    cfg_pattern = pat;
    cfg_len     = len;
    cfg_overlap = ov;
    bit_valid   = v;
    new_bit     = b;
    push_exp(1'b0, 2'd0, 1'b0);
  endtask

  task automatic check_output(input exp_t e);
    n_vec++;
    if (detected !== e.det || match_count !== e.cnt || count_sat !== e.sat) begin
      n_miss++;
      $display("[TB] FAIL vec%0d: got det=%0b cnt=%0d sat=%0b, expected det=%0b cnt=%0d sat=%0b",
               n_vec, detected, match_count, count_sat, e.det, e.cnt, e.sat);
    end
  endtask

  always begin
    @(posedge clk);
    #1;
    if (exp_q.size() != 0) begin
      mon_e = exp_q.pop_front();
      check_output(mon_e);
    end
  end

  initial begin
    reset_cycle();
    reset_cycle();

    // Reset defaults (pattern 0, len 8): eight valid zeros needed to match.
    repeat (7) feed(1'b0, 1'b0, 2'd0);
    feed(1'b0, 1'b1, 2'd1);
    idle(2'd1, 1'b0);

    // Basic match: 110011, len 6.
    configure(8'b00110011, 4'd6, 1'b1, 1'b0, 1'b0);
    feed(1'b1, 1'b0, 2'd0);
    feed(1'b1, 1'b0, 2'd0);
    feed(1'b0, 1'b0, 2'd0);
    feed(1'b0, 1'b0, 2'd0);
    feed(1'b1, 1'b0, 2'd0);
    feed(1'b1, 1'b1, 2'd1);
    idle(2'd1, 1'b0);

    // Overlap mode: 1010 on 101010.
    configure(8'b00001010, 4'd4, 1'b1, 1'b0, 1'b0);
    feed(1'b1, 1'b0, 2'd0);
    feed(1'b0, 1'b0, 2'd0);
    feed(1'b1, 1'b0, 2'd0);
    feed(1'b0, 1'b1, 2'd1);
    feed(1'b1, 1'b0, 2'd1);
    feed(1'b0, 1'b1, 2'd2);

    // Non-overlap mode: same stream, second match suppressed.
    configure(8'b00001010, 4'd4, 1'b0, 1'b0, 1'b0);
    feed(1'b1, 1'b0, 2'd0);
    feed(1'b0, 1'b0, 2'd0);
    feed(1'b1, 1'b0, 2'd0);
    feed(1'b0, 1'b1, 2'd1);
    feed(1'b1, 1'b0, 2'd1);
    feed(1'b0, 1'b0, 2'd1);

    // Gaps and warm-up: 0000 straight after reset.
    reset_cycle();
    configure(8'b00000000, 4'd4, 1'b1, 1'b0, 1'b0);
    feed(1'b0, 1'b0, 2'd0);
    feed(1'b0, 1'b0, 2'd0);
    feed(1'b0, 1'b0, 2'd0);
    idle(2'd0, 1'b0);
    idle(2'd0, 1'b0);
    idle(2'd0, 1'b0);
    feed(1'b0, 1'b1, 2'd1);

    // Oversized length clamps to MAX_LEN.
    configure(8'hFF, 4'd15, 1'b1, 1'b0, 1'b0);
    repeat (7) feed(1'b1, 1'b0, 2'd0);
    feed(1'b1, 1'b1, 2'd1);

    // Zero length disables detection.
    configure(8'h00, 4'd0, 1'b1, 1'b0, 1'b0);
    repeat (5) feed(1'b0, 1'b0, 2'd0);

    // Saturation with a 2-bit counter.
    configure(8'b00000011, 4'd2, 1'b1, 1'b0, 1'b0);
    feed_sat(1'b1, 1'b0, 2'd0, 1'b0);
    feed_sat(1'b1, 1'b1, 2'd1, 1'b0);
    feed_sat(1'b1, 1'b1, 2'd2, 1'b0);
    feed_sat(1'b1, 1'b1, 2'd3, 1'b1);
    feed_sat(1'b1, 1'b1, 2'd3, 1'b1);
    feed_sat(1'b1, 1'b1, 2'd3, 1'b1);
    idle(2'd3, 1'b1);

    // Config write with a valid bit mid-stream: bit dropped, count cleared.
    configure(8'b00001010, 4'd4, 1'b1, 1'b0, 1'b0);
    feed(1'b1, 1'b0, 2'd0);
    feed(1'b0, 1'b0, 2'd0);
    feed(1'b1, 1'b0, 2'd0);
    feed(1'b0, 1'b1, 2'd1);
    configure(8'b00001010, 4'd4, 1'b1, 1'b1, 1'b1);
    feed(1'b0, 1'b0, 2'd0);
    feed(1'b1, 1'b0, 2'd0);
    feed(1'b0, 1'b0, 2'd0);
    feed(1'b1, 1'b0, 2'd0);
    feed(1'b0, 1'b1, 2'd1);

    // Reset after three of four pattern bits discards the partial match.
    configure(8'b00001010, 4'd4, 1'b1, 1'b0, 1'b0);
    feed(1'b1, 1'b0, 2'd0);
    feed(1'b0, 1'b0, 2'd0);
    feed(1'b1, 1'b0, 2'd0);
    reset_cycle();
    feed(1'b0, 1'b0, 2'd0);

    @(negedge clk);
    bit_valid = 1'b0;
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      n_miss++;
      $display("[TB] FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/programmable_sequence_detector.md
PROGRAMMABLE_SEQUENCE_DETECTOR -- requirements
Module: programmable_sequence_detector

Interface
REQ-001 Parameter MAX_LEN, default 8: maximum pattern length in bits, legal range 2..32.
REQ-002 Parameter CNT_W, default 8: width of the match counter, legal range 1..32.
REQ-003 Derived width LEN_W = $clog2(MAX_LEN+1).
REQ-004 clk  input  1  clock; all state updates on the rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 bit_valid  input  1  qualifies new_bit for the current cycle.
REQ-007 new_bit  input  1  serial data bit.
REQ-008 cfg_we  input  1  configuration write strobe.
REQ-009 cfg_pattern  input  MAX_LEN  pattern. Bit [len-1] is the first-arriving bit and bit [0] is the last-arriving bit.
REQ-010 cfg_len  input  LEN_W  pattern length in bits.
REQ-011 cfg_overlap  input  1  mode select: 1 = overlapping matches, 0 = non-overlapping matches.
REQ-012 detected  output  1  registered one-cycle match pulse.
REQ-013 match_count  output  CNT_W  saturating count of matches.
REQ-014 count_sat  output  1  high while match_count equals all-ones.

Function
REQ-015 The block SHALL hold these registers: pattern, len, overlap, a MAX_LEN-bit history shift register, a fill counter (0..MAX_LEN), detected, and match_count.
REQ-016 On a clock edge with cfg_we=1, the block SHALL latch pattern, len and overlap, clear history, clear fill, clear match_count and clear detected; new_bit is discarded in that cycle even if bit_valid=1.
REQ-017 A cfg_len value above MAX_LEN SHALL be latched as MAX_LEN; a cfg_len value of 0 SHALL disable detection (detected stays 0 and match_count holds).
REQ-018 On an edge with cfg_we=0 and bit_valid=1, the block SHALL update history to {history[MAX_LEN-2:0], new_bit} and saturate fill at MAX_LEN.
REQ-019 On an edge with bit_valid=0, history, fill and match_count SHALL hold and detected SHALL be 0 in the next cycle.
REQ-020 A match occurs on an accepting edge when the updated history[len-1:0] equals pattern[len-1:0] and the updated fill is at least len; bits at or above len are ignored.
REQ-021 On a match, detected SHALL be 1 for exactly the one cycle following that edge, giving 1-cycle latency from the completing bit.
REQ-022 On a match, match_count SHALL increment by 1 on the same edge, holding at 2^CNT_W-1 once there.
REQ-023 In overlap mode, history and fill SHALL continue unchanged after a match, so a suffix of one match may begin the next.
REQ-024 In non-overlap mode, fill SHALL be set to 0 on the match edge, so the next match requires len further valid bits.
REQ-025 Gaps in bit_valid SHALL NOT break a sequence; only valid bits form the stream.
REQ-026 count_sat SHALL be combinational from match_count.

Reset
REQ-027 While rst=1 at an edge, the block SHALL clear history, fill, detected and match_count, set pattern=0, set len=MAX_LEN and set overlap=1; rst SHALL take priority over cfg_we and bit_valid.
REQ-028 Reset output values: detected=0, match_count=0, count_sat=0 (or 1 only when CNT_W yields all-ones=0, which is not possible).
REQ-029 Reset asserted mid-sequence SHALL discard partial history; after release, a full len valid bits are required before any match.

Verification
REQ-030 Basic match: MAX_LEN=8, cfg pattern=8'b00110011, len=6, overlap=1; stream 1,1,0,0,1,1 -> detected pulses once, in the cycle after the 6th bit; match_count=1.
REQ-031 Overlap mode: pattern 4'b1010, len=4, overlap=1; stream 1,0,1,0,1,0 -> detected after bits 4 and 6; match_count=2.
REQ-032 Non-overlap mode: same pattern with overlap=0 and the same stream -> detected after bit 4 only; match_count=1.
REQ-033 Gaps and warm-up: pattern 0000, len=4, right after reset; stream 0,0,0 with bit_valid=0 for 3 cycles inserted, then 0 -> no detection before the 4th valid bit, one pulse after it.
REQ-034 Saturation: CNT_W=2, pattern 11, len=2, overlap=1, six 1s -> match_count sequence 0,1,2,3,3,3 and count_sat=1 from the third match.
REQ-035 Reconfiguration and reset: cfg_we with bit_valid=1 in the same cycle mid-stream -> bit dropped and match_count=0; rst after 3 of 4 pattern bits, then 1 more bit -> no detection.
